// File: rtl/sprite_motion_pkg.sv
// Shared constants, register map, FSM state encoding and bus payload types
// for the sprite motion sequencer.
package sprite_motion_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned FCNT_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_CTRL  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_POS   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_VEL   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_BOUND = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_BOUNCE_BIT = 1;
    localparam int unsigned CTRL_BUSY_BIT   = 8;
    localparam int unsigned CTRL_FCNT_LSB   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP_X,
        ST_STEP_Y,
        ST_COMMIT
    } state_t;

    // {y, x} pair used for position, velocity and bound words
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } coord_pair_t;

    // Two's complement negation that saturates the most negative value
    function automatic logic [COORD_W-1:0] neg_sat(input logic [COORD_W-1:0] v);
        logic [COORD_W-1:0] min_neg;
        min_neg = {1'b1, {(COORD_W-1){1'b0}}};
        if (v == min_neg) begin
            neg_sat = ~min_neg;
        end else begin
            neg_sat = COORD_W'(~v + COORD_W'(1));
        end
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// Combinational single-axis motion step: adds a signed velocity to an
// unsigned position, clamps to [0, m] and flags when a bound was hit.
module sprite_axis_step
    import sprite_motion_pkg::*;
(
    input  logic [COORD_W-1:0] p,
    input  logic [COORD_W-1:0] v,
    input  logic [COORD_W-1:0] m,
    output logic [COORD_W-1:0] p_next_c,
    output logic               flip_c
);

    // One bit beyond the 17-bit sum so p near 0xFFFF plus a positive v cannot wrap
    localparam int unsigned SUM_W = COORD_W + 2;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] bound;

    always_comb begin
        sum      = $signed({2'b00, p}) + $signed({{2{v[COORD_W-1]}}, v});
        bound    = $signed({2'b00, m});
        p_next_c = sum[COORD_W-1:0];
        flip_c   = 1'b0;
        if (sum > bound) begin
            p_next_c = m;
            flip_c   = 1'b1;
        end else if (sum[SUM_W-1]) begin
            p_next_c = '0;
            flip_c   = 1'b1;
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion sequencer: Avalon-MM register file, vsync
// synchroniser and the step/commit FSM driving the sprite position word.
module sprite_motion_ctrl
    import sprite_motion_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESET_MAX_X = 639,
    parameter int unsigned RESET_MAX_Y = 479
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic              vsync_n,
    output logic [DATA_W-1:0] pos_out,
    output logic              frame_done
);

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] vsync_sync;
    logic                   vsync_prev;
    logic                   frame_tick;

    logic        ctrl_en;
    logic        ctrl_bounce;
    coord_pair_t vel;
    coord_pair_t bound;
    coord_pair_t pos;
    coord_pair_t pend_pos;
    logic        pend;
    coord_pair_t commit_pos;
    logic        commit_pend;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic [FCNT_W-1:0]  frame_cnt;

    logic wr;
    logic wr_ctrl;
    logic wr_pos;
    logic wr_vel;
    logic wr_bound;
    logic busy;

    logic start_frame;
    logic load_idle;
    logic do_step_x;
    logic do_step_y;
    logic do_commit;

    logic [COORD_W-1:0] step_p;
    logic [COORD_W-1:0] step_v;
    logic [COORD_W-1:0] step_m;
    logic [COORD_W-1:0] step_p_next;
    logic               step_flip;

    assign wr       = chipselect & ~write_n;
    assign wr_ctrl  = wr && (address == ADDR_CTRL);
    assign wr_pos   = wr && (address == ADDR_POS);
    assign wr_vel   = wr && (address == ADDR_VEL);
    assign wr_bound = wr && (address == ADDR_BOUND);
    assign busy     = (state == ST_STEP_X) || (state == ST_STEP_Y) || (state == ST_COMMIT);
    assign pos_out  = pos;

    // vsync_n synchroniser and falling-edge detector, tick one cycle after the last stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_sync <= '1;
            vsync_prev <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], vsync_n};
            vsync_prev <= vsync_sync[SYNC_STAGES-1];
            frame_tick <= vsync_prev & ~vsync_sync[SYNC_STAGES-1];
        end
    end

    // Shared step datapath, muxed between axes
    always_comb begin
        step_p = pos.x;
        step_v = vel.x;
        step_m = bound.x;
        if (state == ST_STEP_Y) begin
            step_p = pos.y;
            step_v = vel.y;
            step_m = bound.y;
        end
    end

    sprite_axis_step u_axis_step (
        .p        (step_p),
        .v        (step_v),
        .m        (step_m),
        .p_next_c (step_p_next),
        .flip_c   (step_flip)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        load_idle   = 1'b0;
        do_step_x   = 1'b0;
        do_step_y   = 1'b0;
        do_commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                load_idle = pend;
                if (ctrl_en) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ctrl_en) begin
                    state_next = ST_IDLE;
                end else if (frame_tick) begin
                    start_frame = 1'b1;
                    state_next  = ST_STEP_X;
                end
            end
            ST_STEP_X: begin
                do_step_x  = 1'b1;
                state_next = ST_STEP_Y;
            end
            ST_STEP_Y: begin
                do_step_y  = 1'b1;
                state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                do_commit  = 1'b1;
                state_next = ST_WAIT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Register file and datapath; a pending POS is claimed at frame start so
    // writes landing mid-sequence are held for the following frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_bounce <= 1'b0;
            vel         <= '0;
            bound       <= '{y: COORD_W'(RESET_MAX_Y), x: COORD_W'(RESET_MAX_X)};
            pos         <= '0;
            pend_pos    <= '0;
            pend        <= 1'b0;
            commit_pos  <= '0;
            commit_pend <= 1'b0;
            nx          <= '0;
            ny          <= '0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= (state_next == ST_COMMIT);

            if (wr_ctrl) begin
                ctrl_en     <= writedata[CTRL_EN_BIT];
                ctrl_bounce <= writedata[CTRL_BOUNCE_BIT];
            end

            if (wr_bound) begin
                bound <= coord_pair_t'(writedata);
            end

            if (wr_vel) begin
                vel <= coord_pair_t'(writedata);
            end else if (ctrl_bounce && step_flip) begin
                if (do_step_x) begin
                    vel.x <= neg_sat(vel.x);
                end
                if (do_step_y) begin
                    vel.y <= neg_sat(vel.y);
                end
            end

            if (start_frame) begin
                commit_pend <= pend;
                commit_pos  <= pend_pos;
            end

            if (wr_pos) begin
                pend_pos <= coord_pair_t'(writedata);
                pend     <= 1'b1;
            end else if (start_frame || load_idle) begin
                pend <= 1'b0;
            end

            if (do_step_x) begin
                nx <= step_p_next;
            end
            if (do_step_y) begin
                ny <= step_p_next;
            end

            if (do_commit) begin
                pos       <= commit_pend ? commit_pos : '{y: ny, x: nx};
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end else if (load_idle) begin
                pos <= pend_pos;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN_BIT]                          = ctrl_en;
                readdata[CTRL_BOUNCE_BIT]                      = ctrl_bounce;
                readdata[CTRL_BUSY_BIT]                        = busy;
                readdata[CTRL_FCNT_LSB +: FCNT_W]              = frame_cnt;
            end
            ADDR_POS:   readdata = pos;
            ADDR_VEL:   readdata = vel;
            ADDR_BOUND: readdata = bound;
            default:    readdata = '0;
        endcase
    end

endmodule
